// File: rtl/phy_tx_pkg.sv
// Shared PHY link constants, lane/frame types and the lane-or-COM select helper.
// Used by phy_tx and its serializer.
package phy_tx_pkg;
    localparam logic [7:0] PHY_COM        = 8'hBC;
    localparam int         PHY_LANES      = 4;
    localparam int         PHY_BYTE_W     = 8;
    localparam int         PHY_FRAME_BITS = PHY_LANES * PHY_BYTE_W;
    localparam int         PHY_CNT_W      = $clog2(PHY_FRAME_BITS);

    typedef logic [PHY_BYTE_W-1:0]     lane_t;
    typedef logic [PHY_FRAME_BITS-1:0] frame_t;

    // An invalid lane carries COM so the receiver sees idle in that slot.
    function automatic lane_t lane_sel(input logic vld, input lane_t dat);
        return vld ? dat : PHY_COM;
    endfunction
endpackage

// File: rtl/phy_tx_piso.sv
// 32-bit parallel-load frame register with a registered serial bit select; 1-cycle latency.
// No backpressure: the frame reloads at every frame boundary and shifts one bit per edge.
module phy_tx_piso
    import phy_tx_pkg::*;
(
    input  logic                 clk_32f,
    input  logic                 reset,
    input  logic                 load_en,
    input  frame_t               frame_in,
    input  logic [PHY_CNT_W-1:0] bit_cnt,
    output logic                 data_out
);
    frame_t frame;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            frame    <= {PHY_LANES{PHY_COM}};
            data_out <= 1'b0;
        end else begin
            data_out <= frame[bit_cnt];
            if (load_en)
                frame <= frame_in;
        end
    end
endmodule

// File: rtl/phy_tx.sv
// PHY transmitter: 4 lanes serialized per 32-bit frame after a COM preamble; lane0 bit0 one edge after load.
// No backpressure; inputs are sampled only on the load edge. Option PHY_TX_COM_CHECK_EN adds com_collision.
module phy_tx
    import phy_tx_pkg::*;
#(
    parameter int PREAMBLE_FRAMES = 4
)(
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_tx0,
    input  logic [7:0] data_tx1,
    input  logic [7:0] data_tx2,
    input  logic [7:0] data_tx3,
    input  logic       valid_tx0,
    input  logic       valid_tx1,
    input  logic       valid_tx2,
    input  logic       valid_tx3,
`ifdef PHY_TX_COM_CHECK_EN
    output logic       com_collision,
`endif
    output logic       data_out,
    output logic       load,
    output logic       active
);
    localparam int               PRE_W    = $clog2(PREAMBLE_FRAMES + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_FRAMES - 1);

    logic [PHY_CNT_W-1:0] bit_cnt;
    logic [PRE_W-1:0]     pre_cnt;
    logic                 frame_end;
    frame_t               frame_next;
    lane_t                lane_dat [PHY_LANES];
    logic [PHY_LANES-1:0] lane_vld;

    assign lane_dat[0] = data_tx0;
    assign lane_dat[1] = data_tx1;
    assign lane_dat[2] = data_tx2;
    assign lane_dat[3] = data_tx3;
    assign lane_vld    = {valid_tx3, valid_tx2, valid_tx1, valid_tx0};

    assign frame_end = (bit_cnt == PHY_CNT_W'(PHY_FRAME_BITS - 1));

    always_comb begin
        frame_next = {PHY_LANES{PHY_COM}};
        if (active) begin
            for (int i = 0; i < PHY_LANES; i++)
                frame_next[i*PHY_BYTE_W +: PHY_BYTE_W] = lane_sel(lane_vld[i], lane_dat[i]);
        end
    end

    // load is registered one cycle early so it is high during bit_cnt==31, the sampling cycle.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            pre_cnt <= '0;
            active  <= 1'b0;
            load    <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
            load    <= active && (bit_cnt == PHY_CNT_W'(PHY_FRAME_BITS - 2));
            if (frame_end && !active) begin
                pre_cnt <= pre_cnt + 1'b1;
                if (pre_cnt == PRE_LAST)
                    active <= 1'b1;
            end
        end
    end

`ifdef PHY_TX_COM_CHECK_EN
    logic [PHY_LANES-1:0] lane_hit;

    always_comb begin
        lane_hit = '0;
        for (int i = 0; i < PHY_LANES; i++)
            lane_hit[i] = lane_vld[i] && (lane_dat[i] == PHY_COM);
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset)
            com_collision <= 1'b0;
        else if (frame_end && active && (|lane_hit))
            com_collision <= 1'b1;
    end
`endif

    phy_tx_piso u_piso (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .load_en  (frame_end),
        .frame_in (frame_next),
        .bit_cnt  (bit_cnt),
        .data_out (data_out)
    );
endmodule

// File: tb/tb_phy_tx.sv
// Randomized bench for phy_tx against an edge-count based frame model.
module tb_phy_tx;
    localparam int         PF  = 4;
    localparam logic [7:0] COM = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [7:0] dtx [4];
    logic       vtx [4];
    logic       data_out, load, active;
`ifdef PHY_TX_COM_CHECK_EN
    logic       com_collision;
`endif

    int          tests = 0;
    int          fails = 0;
    int          n;          // edges since reset release
    logic [31:0] cur;        // frame currently being serialized
    logic [31:0] last32;     // last 32 received bits, first-received in bit 0
    logic        coll_m;

    phy_tx #(.PREAMBLE_FRAMES(PF)) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_tx0  (dtx[0]),
        .data_tx1  (dtx[1]),
        .data_tx2  (dtx[2]),
        .data_tx3  (dtx[3]),
        .valid_tx0 (vtx[0]),
        .valid_tx1 (vtx[1]),
        .valid_tx2 (vtx[2]),
        .valid_tx3 (vtx[3]),
`ifdef PHY_TX_COM_CHECK_EN
        .com_collision (com_collision),
`endif
        .data_out  (data_out),
        .load      (load),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at n=%0d t=%0t", tag, got, exp, n, $time);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        cur    = {4{COM}};
        last32 = '0;
        coll_m = 1'b0;
    endtask

    task automatic tick();
        logic exp_bit;
        @(posedge clk_32f);
        n++;
        exp_bit = cur[(n-1) % 32];
        if (n % 32 == 0) begin
            if (n / 32 > PF) begin
                for (int i = 0; i < 4; i++) begin
                    cur[i*8 +: 8] = vtx[i] ? dtx[i] : COM;
                    if (vtx[i] && dtx[i] == COM) coll_m = 1'b1;
                end
            end else begin
                cur = {4{COM}};
            end
        end
        #1;
        last32 = {data_out, last32[31:1]};
        check("data_out", data_out, exp_bit);
        check("active", active, n >= 32*PF);
        check("load", load, (n % 32 == 31) && (n >= 32*PF + 31));
`ifdef PHY_TX_COM_CHECK_EN
        check("com_collision", com_collision, coll_m);
`endif
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) begin
            vtx[i] = 1'($urandom_range(0, 1));
            dtx[i] = ($urandom_range(0, 7) == 0) ? COM : 8'($urandom);
        end
    endtask

    // Runs to the next load edge with random filler, then presents d/v for sampling.
    task automatic load_frame(input logic [31:0] d, input logic [3:0] v);
        while (n % 32 != 31) begin
            rand_inputs();
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            dtx[i] = d[i*8 +: 8];
            vtx[i] = v[i];
        end
        tick();
    endtask

    task automatic run_frame();
        for (int i = 0; i < 32; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            dtx[i] = 8'h00;
            vtx[i] = 1'b0;
        end
        model_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_data_out", data_out, 1'b0);
        check("rst_load", load, 1'b0);
        check("rst_active", active, 1'b0);
        repeat (3) @(posedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b1;

        // Preamble with all lanes invalid, plus one idle data frame.
        for (int i = 0; i < 32*PF + 32; i++) begin
            for (int j = 0; j < 4; j++) dtx[j] = 8'($urandom);
            tick();
        end
        check("preamble_word", last32, 32'hBCBCBCBC);

        load_frame(32'hCCEEDDFF, 4'b1111);
        run_frame();
        check("all_valid_word", last32, 32'hCCEEDDFF);

        load_frame(32'h88AA5599, 4'b1101);
        run_frame();
        check("lane1_idle_word", last32, 32'h88AABC99);

        load_frame(32'h33221177 & 32'hFFFFFF00 | 32'h77, 4'b1111);
        do tick(); while (n % 32 != 10);
        dtx[0] = 8'h11;
        do tick(); while (n % 32 != 0);
        check("held_lane0", {24'h0, last32[7:0]}, 32'h77);
        run_frame();
        check("next_lane0", {24'h0, last32[7:0]}, 32'h11);

`ifdef PHY_TX_COM_CHECK_EN
        load_frame(32'h12BC5634, 4'b1111);
        tick();
        check("coll_set", com_collision, 1'b1);
        do tick(); while (n % 32 != 0);
        check("coll_slot2", {24'h0, last32[23:16]}, 32'hBC);
        load_frame(32'h01020304, 4'b1111);
        run_frame();
        check("coll_sticky", com_collision, 1'b1);
`endif

        // Reset in the middle of a data frame.
        load_frame(32'hA5A5A5A5, 4'b1111);
        do tick(); while (n % 32 != 13);
        reset = 1'b0;
        #1;
        check("midrst_data_out", data_out, 1'b0);
        check("midrst_active", active, 1'b0);
        check("midrst_load", load, 1'b0);
        repeat (2) @(posedge clk_32f);
        #1;
        check("midrst_hold", {30'h0, active, data_out}, 32'h0);
        @(negedge clk_32f);
        model_reset();
        reset = 1'b1;

        // Valid inputs during the restarted preamble must not leak out.
        for (int i = 0; i < 32*PF + 32; i++) begin
            for (int j = 0; j < 4; j++) begin
                vtx[j] = 1'b1;
                dtx[j] = 8'($urandom);
            end
            tick();
        end

        // Fully random inputs changing every cycle.
        for (int i = 0; i < 32*30; i++) begin
            rand_inputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
